rng_bit_packer: RTL and testbench

//  Downstream consumer of the D-flip-flop shift chain that forms the RNG core.

---
 rtl/rng_pkg.sv | 15 +
 rtl/rng_bit_packer_if.sv | 27 ++
 rtl/rng_vn_corrector.sv | 44 ++++
 rtl/rng_bit_packer.sv | 80 ++++++++
 tb/tb_rng_bit_packer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/rng_pkg.sv
// Shared constants and von Neumann pair encodings for the RNG bit packer slice.
package rng_pkg;

  localparam int unsigned RNG_WORD_W_DEF = 8;
  localparam int unsigned RNG_DROP_W_DEF = 8;

  // Pair encoding is {first, second} as sampled from the flip-flop chain.
  typedef enum logic [1:0] {
    VN_PAIR_00 = 2'b00,
    VN_PAIR_01 = 2'b01,
    VN_PAIR_10 = 2'b10,
    VN_PAIR_11 = 2'b11
  } vn_pair_t;

endpackage

// File: rtl/rng_bit_packer_if.sv
// Bit input and word output bundle of rng_bit_packer; slave is the packer side.
interface rng_bit_packer_if
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH  = RNG_WORD_W_DEF,
  parameter int unsigned DROP_W = RNG_DROP_W_DEF
) ();

  logic              i_bit;
  logic              i_bit_vld;
  logic [WIDTH-1:0]  o_word;
  logic              o_word_vld;
  logic              i_word_rdy;
  logic              o_overrun;
  logic [DROP_W-1:0] o_drop_cnt;

  modport slave (
    input  i_bit, i_bit_vld, i_word_rdy,
    output o_word, o_word_vld, o_overrun, o_drop_cnt
  );

  modport master (
    output i_bit, i_bit_vld, i_word_rdy,
    input  o_word, o_word_vld, o_overrun, o_drop_cnt
  );

endinterface

// File: rtl/rng_vn_corrector.sv
// Von Neumann debiaser: emits first bit of a differing pair combinationally on the pair's second bit.
module rng_vn_corrector
  import rng_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_bit,
  input  logic i_bit_vld,
  output logic o_bit,
  output logic o_bit_vld
);

  logic     r_have_first;
  logic     r_first;
  vn_pair_t w_pair;

  assign w_pair = vn_pair_t'({r_first, i_bit});

  always_comb begin
    o_bit     = r_first;
    o_bit_vld = 1'b0;
    if (i_bit_vld && r_have_first) begin
      case (w_pair)
        VN_PAIR_10, VN_PAIR_01: o_bit_vld = 1'b1;
        default:                o_bit_vld = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_have_first <= 1'b0;
      r_first      <= 1'b0;
    end else if (i_bit_vld) begin
      if (!r_have_first) begin
        r_first      <= i_bit;
        r_have_first <= 1'b1;
      end else begin
        r_have_first <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rng_bit_packer.sv
// Packs RNG chain bits MSB-first into words on a valid/ready port, counting words lost to stalls.
// Define RNG_VON_NEUMANN_EN to insert the von Neumann corrector ahead of the packer.
module rng_bit_packer
  import rng_pkg::*;
#(
  parameter int unsigned WIDTH  = RNG_WORD_W_DEF,
  parameter int unsigned DROP_W = RNG_DROP_W_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rng_bit_packer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic              w_e;
  logic              w_e_vld;
  logic [WIDTH-1:0]  w_shift;
  logic              w_complete;
  logic              w_slot_free;

  logic [WIDTH-2:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_word;
  logic              r_word_vld;
  logic              r_overrun;
  logic [DROP_W-1:0] r_drop_cnt;

`ifdef RNG_VON_NEUMANN_EN
  rng_vn_corrector u_vn (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_bit     (bus.i_bit),
    .i_bit_vld (bus.i_bit_vld),
    .o_bit     (w_e),
    .o_bit_vld (w_e_vld)
  );
`else
  assign w_e     = bus.i_bit;
  assign w_e_vld = bus.i_bit_vld;
`endif

  // Only WIDTH-1 bits need holding: the completing bit is taken straight from w_e.
  assign w_shift     = {r_acc, w_e};
  assign w_complete  = w_e_vld && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_slot_free = !r_word_vld || bus.i_word_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_word     <= '0;
      r_word_vld <= 1'b0;
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_e_vld) begin
        r_acc <= w_shift[WIDTH-2:0];
        r_cnt <= w_complete ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_complete) begin
        if (w_slot_free) begin
          r_word     <= w_shift;
          r_word_vld <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
          if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
      end else if (r_word_vld && bus.i_word_rdy) begin
        r_word_vld <= 1'b0;
      end
    end
  end

  assign bus.o_word     = r_word;
  assign bus.o_word_vld = r_word_vld;
  assign bus.o_overrun  = r_overrun;
  assign bus.o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_rng_bit_packer.sv
// Self-checking bench for rng_bit_packer; data bits become (b, ~b) raw pairs when RNG_VON_NEUMANN_EN is defined.
module tb_rng_bit_packer;
  import rng_pkg::*;

  logic clk;
  logic rst;
  logic tb_bit;
  logic tb_vld;
  logic rdy_a;
  logic rdy_b;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  sb_q[$];

  rng_bit_packer_if #(.WIDTH(8), .DROP_W(8)) bus_a ();
  rng_bit_packer_if #(.WIDTH(8), .DROP_W(2)) bus_b ();

  assign bus_a.i_bit      = tb_bit;
  assign bus_a.i_bit_vld  = tb_vld;
  assign bus_a.i_word_rdy = rdy_a;
  assign bus_b.i_bit      = tb_bit;
  assign bus_b.i_bit_vld  = tb_vld;
  assign bus_b.i_word_rdy = rdy_b;

  rng_bit_packer #(.WIDTH(8), .DROP_W(8)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
  rng_bit_packer #(.WIDTH(8), .DROP_W(2)) dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic       exp_ovr;
    logic [7:0] exp_drop;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: scoreboard sampled on the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    if (bus_a.o_word_vld && rdy_a) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got word %0h expected none", bus_a.o_word);
      end else begin
        chk("sb_word", {24'h0, bus_a.o_word}, {24'h0, sb_q.pop_front()});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic raw(input logic b);
    tb_bit = b;
    tb_vld = 1'b1;
    step();
    tb_vld = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic pulse);
`ifdef RNG_VON_NEUMANN_EN
    tb_bit = b;
    tb_vld = 1'b1;
    step();
    tb_bit = ~b;
    if (pulse) rdy_a = 1'b1;
    step();
`else
    tb_bit = b;
    tb_vld = 1'b1;
    if (pulse) rdy_a = 1'b1;
    step();
`endif
    tb_vld = 1'b0;
    if (pulse) rdy_a = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic pulse_last);
    for (int i = 7; i >= 0; i--) send_bit(w[i], pulse_last && (i == 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    tb_bit = 1'b0;
    tb_vld = 1'b0;
    rdy_a  = 1'b0;
    rdy_b  = 1'b0;
    tbl[0] = '{8'hA5, 1'b0, 8'h00};
    tbl[1] = '{8'h3C, 1'b0, 8'h00};
    tbl[2] = '{8'h00, 1'b0, 8'h00};
    tbl[3] = '{8'hFF, 1'b0, 8'h00};
    tbl[4] = '{8'h5A, 1'b0, 8'h00};

    // Reset state and reset mid-word
    step();
    chk("rst_word", {24'h0, bus_a.o_word}, 32'h0);
    chk("rst_vld", {31'h0, bus_a.o_word_vld}, 32'h0);
    chk("rst_ovr", {31'h0, bus_a.o_overrun}, 32'h0);
    chk("rst_drop", {24'h0, bus_a.o_drop_cnt}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    raw(1'b1);
    do_reset();
    chk("midrst_vld", {31'h0, bus_a.o_word_vld}, 32'h0);
    send_word(8'hB2, 1'b0);
    chk("midrst_word", {24'h0, bus_a.o_word}, 32'hB2);
    chk("midrst_vld2", {31'h0, bus_a.o_word_vld}, 32'h1);

    // Steady ready, table-driven
    do_reset();
    rdy_a = 1'b1;
    foreach (tbl[k]) begin
      sb_q.push_back(tbl[k].word);
      send_word(tbl[k].word, 1'b0);
      step();
      chk("steady_ovr", {31'h0, bus_a.o_overrun}, {31'h0, tbl[k].exp_ovr});
      chk("steady_drop", {24'h0, bus_a.o_drop_cnt}, {24'h0, tbl[k].exp_drop});
      chk("steady_vld", {31'h0, bus_a.o_word_vld}, 32'h0);
    end
    chk("steady_sb_empty", sb_q.size(), 32'h0);
    rdy_a = 1'b0;

    // Stall with two dropped words, then consume the held one
    do_reset();
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b0);
    send_word(8'h03, 1'b0);
    chk("stall_word", {24'h0, bus_a.o_word}, 32'h01);
    chk("stall_vld", {31'h0, bus_a.o_word_vld}, 32'h1);
    chk("stall_ovr", {31'h0, bus_a.o_overrun}, 32'h1);
    chk("stall_drop", {24'h0, bus_a.o_drop_cnt}, 32'h2);
    sb_q.push_back(8'h01);
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    chk("stall_take_vld", {31'h0, bus_a.o_word_vld}, 32'h0);
    chk("stall_ovr_sticky", {31'h0, bus_a.o_overrun}, 32'h1);
    chk("stall_sb_empty", sb_q.size(), 32'h0);

    // Consume and complete on the same edge
    do_reset();
    send_word(8'h11, 1'b0);
    sb_q.push_back(8'h11);
    send_word(8'h22, 1'b1);
    chk("simul_vld", {31'h0, bus_a.o_word_vld}, 32'h1);
    chk("simul_word", {24'h0, bus_a.o_word}, 32'h22);
    chk("simul_drop", {24'h0, bus_a.o_drop_cnt}, 32'h0);
    chk("simul_ovr", {31'h0, bus_a.o_overrun}, 32'h0);
    sb_q.push_back(8'h22);
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    chk("simul_take_vld", {31'h0, bus_a.o_word_vld}, 32'h0);
    chk("simul_sb_empty", sb_q.size(), 32'h0);

    // Drop counter saturation on the DROP_W=2 instance
    do_reset();
    for (int w = 0; w < 4; w++) send_word(8'h40 + 8'(w), 1'b0);
    chk("sat_drop3", {30'h0, bus_b.o_drop_cnt}, 32'h3);
    send_word(8'h44, 1'b0);
    send_word(8'h45, 1'b0);
    chk("sat_drop_hold", {30'h0, bus_b.o_drop_cnt}, 32'h3);
    chk("sat_ovr", {31'h0, bus_b.o_overrun}, 32'h1);
    chk("sat_word", {24'h0, bus_b.o_word}, 32'h40);
    chk("sat_wide_drop", {24'h0, bus_a.o_drop_cnt}, 32'h5);

`ifdef RNG_VON_NEUMANN_EN
    // Raw pair stream through the corrector
    begin
      logic [19:0] pairs;
      pairs = 20'b10_01_11_00_10_10_01_01_10_01;
      do_reset();
      for (int i = 19; i >= 0; i--) raw(pairs[i]);
      chk("vn_word", {24'h0, bus_a.o_word}, 32'hB2);
      chk("vn_vld", {31'h0, bus_a.o_word_vld}, 32'h1);
      chk("vn_drop", {24'h0, bus_a.o_drop_cnt}, 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
